uart_fifo_core: RTL

//  Parametrised full-duplex UART: TX with valid/ready byte input, RX with show-ahead FIFO.

---
 rtl/uart_fifo_core.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with configurable frame format.
// TX takes a valid/ready byte; RX deframes into a show-ahead FIFO and reports
// framing errors, parity errors and overrun as single-cycle pulses.
module uart_fifo_core #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Counter terminal values: full bit, half bit (start-bit centre) and the
  // stop phase minus one cycle, so tx_ready is already up in the final stop
  // cycle and a back-to-back byte follows with no idle gap.
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_STOP_END = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BITS - 1);
  localparam logic [AW:0]      FIFO_FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic             HAS_PARITY   = (PARITY != 0);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PARITY, T_STOP
  } tx_state_t;

  // Parity bit for a data word: even = XOR of the bits, odd = its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = (^d) ^ (PARITY == 1);
  endfunction

  logic                 rx_meta, rx_sync;
  rx_state_t            rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bad;
  logic                 push_vld_p1;

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_accept;

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 fifo_full, do_pop, do_push;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // RX deframer: start-bit centre check, then one sample per bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= R_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_par_bad    <= 1'b0;
      push_vld_p1   <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      push_vld_p1   <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          rx_cnt     <= '0;
          rx_bit     <= '0;
          rx_par_bad <= 1'b0;
          if (!rx_sync) rx_state <= R_START;
        end
        R_START: begin
          if (rx_cnt == CNT_HALF_END) begin
            rx_cnt   <= '0;
            // A line back high at the start-bit centre was only a glitch.
            rx_state <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt == CNT_BIT_END) begin
            rx_cnt <= '0;
            if (rx_bit == BIT_LAST) rx_state <= HAS_PARITY ? R_PARITY : R_STOP;
            else                    rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_PARITY: begin
          if (rx_cnt == CNT_BIT_END) begin
            rx_cnt     <= '0;
            rx_par_bad <= (rx_sync != parity_of(rx_shift));
            rx_state   <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_STOP: begin
          // Only the first stop bit is checked; a second one just reads as idle.
          if (rx_cnt == CNT_BIT_END) begin
            rx_cnt <= '0;
            if (!rx_sync) begin
              rx_frame_err <= 1'b1;
              rx_state     <= R_WAIT_HIGH;
            end else begin
              push_vld_p1   <= 1'b1;
              rx_parity_err <= rx_par_bad;
              rx_state      <= R_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_WAIT_HIGH: begin
          if (rx_sync) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // RX data shift register, LSB first; holds the byte until the next frame.
  always_ff @(posedge clk) begin
    if (rx_state == R_DATA && rx_cnt == CNT_BIT_END)
      rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
  end

  // ---- stage p1: completed byte (push_vld_p1, rx_shift) enters the FIFO ----
  assign fifo_full = (rx_count == FIFO_FULL);
  assign rx_valid  = (rx_count != '0);
  assign do_pop    = rx_valid && rx_ready;
  assign do_push   = push_vld_p1 && (!fifo_full || do_pop);
  assign rx_data   = fifo_mem[rd_ptr];

  // FIFO pointers and occupancy; a push into a full FIFO is dropped unless a
  // pop frees the slot in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= push_vld_p1 && fifo_full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= rx_shift;
  end

  assign tx_accept = tx_valid && tx_ready;

  // TX data path: latch byte and its parity on accept, shift out LSB first.
  always_ff @(posedge clk) begin
    if (tx_accept) begin
      tx_shift <= tx_data;
      tx_par   <= parity_of(tx_data);
    end else if (tx_state == T_DATA && tx_cnt == CNT_BIT_END) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // TX framer: each bit held CLKS_PER_BIT cycles, registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      uart_tx  <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        T_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (tx_accept) begin
            uart_tx  <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt == CNT_BIT_END) begin
            tx_cnt   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= T_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        T_DATA: begin
          if (tx_cnt == CNT_BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              uart_tx  <= HAS_PARITY ? tx_par : 1'b1;
              tx_state <= HAS_PARITY ? T_PARITY : T_STOP;
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              uart_tx <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        T_PARITY: begin
          if (tx_cnt == CNT_BIT_END) begin
            tx_cnt   <= '0;
            uart_tx  <= 1'b1;
            tx_state <= T_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        T_STOP: begin
          // The last stop cycle is spent in IDLE with tx_ready already high.
          if (tx_cnt == CNT_STOP_END) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= T_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule
